// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, default width.
package mdu_pkg;
    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/mdu_step.sv
// Single iteration kernel: shift-add multiply step or restoring-divide trial subtract.
// Purely combinational; no flow control.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] pr;
    logic [WIDTH:0] diff;

    always_comb begin
        // Multiply: {high, multiplier} shifts right; the carry lands in the top bit.
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & operand};
        // Divide: {remainder, dividend/quotient} shifts left; quotient bits enter at bit 0.
        pr   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = pr - {1'b0, operand};
        if (is_div) begin
            if (diff[WIDTH]) acc_next = {pr[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else             acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-step multiply/divide feeding the register-file write port; MDU_SIGNED_EN selects signed ops.
// Latency: start at E0, result and one-cycle L_S after E32; busy ignores start until back in IDLE.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rdata_A,
    input  logic [WIDTH-1:0] rdata_B,
    input  logic [4:0]       dst_addr,
    output logic             busy,
    output logic             done,
    output logic             L_S,
    output logic [4:0]       Wt_addr,
    output logic [WIDTH-1:0] Wt_data
);
    localparam int CW = $clog2(WIDTH);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   opnd;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_in, b_in;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, result;
`ifdef MDU_SIGNED_EN
    logic               sign_a, sign_b;
`endif

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (opnd),
        .is_div   (op_q[1]),
        .acc_next (acc_next)
    );

    always_comb begin
`ifdef MDU_SIGNED_EN
        a_in = rdata_A[WIDTH-1] ? -rdata_A : rdata_A;
        b_in = rdata_B[WIDTH-1] ? -rdata_B : rdata_B;
`else
        a_in = rdata_A;
        b_in = rdata_B;
`endif
    end

    always_comb begin
        prod = acc_next;
        quo  = acc_next[WIDTH-1:0];
        rem  = acc_next[2*WIDTH-1:WIDTH];
`ifdef MDU_SIGNED_EN
        // Divide by zero keeps the all-ones quotient and returns A via the dividend sign.
        if (sign_a ^ sign_b)                 prod = -acc_next;
        if ((sign_a ^ sign_b) && opnd != '0) quo  = -acc_next[WIDTH-1:0];
        if (sign_a)                          rem  = -acc_next[2*WIDTH-1:WIDTH];
`endif
        case (op_q)
            OP_MUL:  result = prod[WIDTH-1:0];
            OP_MULH: result = prod[2*WIDTH-1:WIDTH];
            OP_DIV:  result = quo;
            default: result = rem;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            op_q    <= OP_MUL;
            Wt_addr <= '0;
            Wt_data <= '0;
`ifdef MDU_SIGNED_EN
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    cnt     <= CW'(WIDTH - 1);
                    op_q    <= op;
                    Wt_addr <= dst_addr;
                    if (op[1]) begin
                        acc  <= {{WIDTH{1'b0}}, a_in};
                        opnd <= b_in;
                    end else begin
                        acc  <= {{WIDTH{1'b0}}, b_in};
                        opnd <= a_in;
                    end
`ifdef MDU_SIGNED_EN
                    sign_a <= rdata_A[WIDTH-1];
                    sign_b <= rdata_B[WIDTH-1];
`endif
                end
                CALC: begin
                    acc <= acc_next;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else           Wt_data <= result;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign L_S  = done;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; expectations depend on MDU_SIGNED_EN.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rdata_A = '0;
    logic [31:0] rdata_B = '0;
    logic [4:0]  dst_addr = '0;
    logic        busy, done, L_S;
    logic [4:0]  Wt_addr;
    logic [31:0] Wt_data;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .rdata_A  (rdata_A),
        .rdata_B  (rdata_B),
        .dst_addr (dst_addr),
        .busy     (busy),
        .done     (done),
        .L_S      (L_S),
        .Wt_addr  (Wt_addr),
        .Wt_data  (Wt_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launches one operation at E0 and checks timing through E36.
    // glitch_at > 0 pulses a second start at that edge with different operands.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input logic [31:0] exp, input string tag,
                          input int glitch_at);
        int pulses = 0;
        @(negedge clk);
        op = o; rdata_A = a; rdata_B = b; dst_addr = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rdata_A = $urandom; rdata_B = $urandom; dst_addr = ~d; op = ~o;
        check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 36; i++) begin
            @(posedge clk); #1;
            if (L_S) pulses++;
            if (glitch_at > 0 && i == glitch_at - 1) begin
                start = 1'b1; rdata_A = 32'd3; rdata_B = 32'd3; dst_addr = 5'd9; op = 2'b00;
            end
            if (glitch_at > 0 && i == glitch_at) start = 1'b0;
            if (i == 31) check({tag, "_ls_early"}, {31'd0, L_S}, 32'd0);
            if (i == 32) begin
                check({tag, "_ls"},    {31'd0, L_S},  32'd1);
                check({tag, "_done"},  {31'd0, done}, 32'd1);
                check({tag, "_busy"},  {31'd0, busy}, 32'd1);
                check({tag, "_addr"},  {27'd0, Wt_addr}, {27'd0, d});
                check({tag, "_data"},  Wt_data, exp);
            end
            if (i == 33) begin
                check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
                check({tag, "_ls_off"},    {31'd0, L_S},  32'd0);
                check({tag, "_hold"},      Wt_data, exp);
            end
        end
        check({tag, "_pulses"}, pulses, 32'd1);
    endtask

    initial begin
        int pulses;
        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ls",   {31'd0, L_S},  32'd0);
        check("rst_addr", {27'd0, Wt_addr}, 32'd0);
        check("rst_data", Wt_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op(2'b00, 32'd7, 32'd6, 5'd5, 32'd42, "mul", 0);
`ifdef MDU_SIGNED_EN
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'h00000000, "mulh", 0);
`else
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, "mulh", 0);
`endif
        run_op(2'b10, 32'd100, 32'd7, 5'd7,  32'd14, "div", 0);
        run_op(2'b11, 32'd100, 32'd7, 5'd8,  32'd2,  "rem", 0);
        run_op(2'b10, 32'd5,   32'd0, 5'd10, 32'hFFFFFFFF, "div0", 0);
        run_op(2'b11, 32'd5,   32'd0, 5'd11, 32'd5,  "rem0", 0);
        run_op(2'b00, 32'h12345678, 32'h10, 5'd0, 32'h23456780, "mul_dst0", 0);
`ifdef MDU_SIGNED_EN
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 5'd12, 32'hFFFFFFFD, "sdiv", 0);
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, 5'd13, 32'hFFFFFFFF, "srem", 0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, "sdiv_ovf", 0);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0, "srem_ovf", 0);
`else
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 5'd12, 32'h7FFFFFFC, "udiv", 0);
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, 5'd13, 32'd1, "urem", 0);
`endif
        run_op(2'b00, 32'd7, 32'd6, 5'd5, 32'd42, "glitch", 10);

        // Abort by reset at E15 of a divide.
        @(negedge clk);
        op = 2'b10; rdata_A = 32'd100; rdata_B = 32'd7; dst_addr = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 15; i++) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_ls",   {31'd0, L_S},  32'd0);
        check("abort_data", Wt_data, 32'd0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (L_S) pulses++;
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (L_S) pulses++;
        end
        check("abort_no_ls", pulses, 32'd0);
        check("abort_idle",  {31'd0, busy}, 32'd0);
        run_op(2'b11, 32'd100, 32'd7, 5'd4, 32'd2, "post_rst", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
